// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a four-state debounce filter.
// Produces a clean level, single-cycle rise/fall pulses and a wrapping rise counter.
module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_raw,
    input  logic       en,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [7:0] edge_count
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [7:0] edge_count_q, edge_count_d;

    // Next-state logic: synchroniser always shifts, filter only advances when enabled
    always_comb begin
        s1_d         = d_raw;
        s2_d         = s1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        edge_count_d = edge_count_q;
        if (en) begin
            case (state_q)
                ST_LOW: begin
                    if (s2_q) begin
                        state_d = ST_WAIT_HIGH;
                        cnt_d   = 8'd1;
                    end else begin
                        cnt_d   = 8'd0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!s2_q) begin
                        state_d = ST_LOW;
                        cnt_d   = 8'd0;
                    end else if (cnt_q >= STABLE_C) begin
                        // >= rather than == so a corrupted count still resolves
                        state_d      = ST_HIGH;
                        cnt_d        = 8'd0;
                        level_d      = 1'b1;
                        rise_d       = 1'b1;
                        edge_count_d = edge_count_q + 8'd1;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (!s2_q) begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = 8'd1;
                    end else begin
                        cnt_d   = 8'd0;
                    end
                end
                ST_WAIT_LOW: begin
                    if (s2_q) begin
                        state_d = ST_HIGH;
                        cnt_d   = 8'd0;
                    end else if (cnt_q >= STABLE_C) begin
                        state_d = ST_LOW;
                        cnt_d   = 8'd0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = 8'd0;
                    level_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            state_q      <= ST_LOW;
            cnt_q        <= 8'd0;
            level_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            edge_count_q <= 8'd0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign edge_count = edge_count_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync with STABLE_CYCLES=4.
// Inputs change 1 time unit after a posedge; outputs are sampled at that same point.
module tb_debounce_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_raw;
    logic       en;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] edge_count;

    int checks   = 0;
    int failures = 0;
    int rise_total = 0;
    int fall_total = 0;
    int rise_mark;
    int fall_mark;

    debounce_sync #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_raw      (d_raw),
        .en         (en),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .edge_count (edge_count)
    );

    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle
    always @(negedge clk) begin
        if (rise) rise_total <= rise_total + 1;
        if (fall) fall_total <= fall_total + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic lv, input logic r, input logic f,
                             input logic [7:0] ec);
        check({tag, "_level"}, {15'd0, level}, {15'd0, lv});
        check({tag, "_rise"},  {15'd0, rise},  {15'd0, r});
        check({tag, "_fall"},  {15'd0, fall},  {15'd0, f});
        check({tag, "_count"}, {8'd0, edge_count}, {8'd0, ec});
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        d_raw = 1'b0;

        // 1. reset hold with toggling input
        for (int i = 0; i < 10; i++) begin
            d_raw = ~d_raw;
            step(1);
            check_out("reset_hold", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        d_raw = 1'b0;
        reset = 1'b0;
        step(4);
        check_out("idle", 1'b0, 1'b0, 1'b0, 8'd0);

        // 2. clean rise then fall
        rise_mark = rise_total;
        fall_mark = fall_total;
        d_raw = 1'b1;
        step(6);
        check_out("rise_e5", 1'b0, 1'b0, 1'b0, 8'd0);
        step(1);
        check_out("rise_e6", 1'b1, 1'b1, 1'b0, 8'd1);
        step(1);
        check_out("rise_e7", 1'b1, 1'b0, 1'b0, 8'd1);
        step(12);
        d_raw = 1'b0;
        step(6);
        check_out("fall_e5", 1'b1, 1'b0, 1'b0, 8'd1);
        step(1);
        check_out("fall_e6", 1'b0, 1'b0, 1'b1, 8'd1);
        step(1);
        check_out("fall_e7", 1'b0, 1'b0, 1'b0, 8'd1);
        check("clean_rise_n", 16'(rise_total - rise_mark), 16'd1);
        check("clean_fall_n", 16'(fall_total - fall_mark), 16'd1);

        // 3. four-cycle glitch rejected, five-cycle run accepted
        rise_mark = rise_total;
        d_raw = 1'b1;
        step(4);
        d_raw = 1'b0;
        step(10);
        check("glitch_level", {15'd0, level}, 16'd0);
        check("glitch_rise_n", 16'(rise_total - rise_mark), 16'd0);
        d_raw = 1'b1;
        step(5);
        d_raw = 1'b0;
        step(2);
        check_out("five_e6", 1'b1, 1'b1, 1'b0, 8'd2);
        step(10);
        check_out("five_after", 1'b0, 1'b0, 1'b0, 8'd2);

        // 4. bounce 1,0,1,1,0,1 then steady high
        rise_mark = rise_total;
        d_raw = 1'b1; step(1);
        d_raw = 1'b0; step(1);
        d_raw = 1'b1; step(2);
        d_raw = 1'b0; step(1);
        d_raw = 1'b1; step(1);
        step(5);
        check_out("bounce_e5", 1'b0, 1'b0, 1'b0, 8'd2);
        step(1);
        check_out("bounce_e6", 1'b1, 1'b1, 1'b0, 8'd3);
        step(4);
        check("bounce_rise_n", 16'(rise_total - rise_mark), 16'd1);
        d_raw = 1'b0;
        step(10);
        check("bounce_low", {15'd0, level}, 16'd0);

        // 5. enable freeze while waiting for a rise
        d_raw = 1'b1;
        step(3);
        en = 1'b0;
        rise_mark = rise_total;
        fall_mark = fall_total;
        step(10);
        check_out("frozen", 1'b0, 1'b0, 1'b0, 8'd3);
        check("frozen_rise_n", 16'(rise_total - rise_mark), 16'd0);
        check("frozen_fall_n", 16'(fall_total - fall_mark), 16'd0);
        en = 1'b1;
        step(3);
        check_out("resume_e15", 1'b0, 1'b0, 1'b0, 8'd3);
        step(1);
        check_out("resume_e16", 1'b1, 1'b1, 1'b0, 8'd4);
        step(1);

        // 6a. reset while high, then release with input already high
        fall_mark = fall_total;
        reset = 1'b1;
        step(1);
        check_out("midreset", 1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
        step(6);
        check_out("release_r5", 1'b0, 1'b0, 1'b0, 8'd0);
        step(1);
        check_out("release_r6", 1'b1, 1'b1, 1'b0, 8'd1);
        check("midreset_fall_n", 16'(fall_total - fall_mark), 16'd0);

        // 6b. wrap the rise counter through 255 -> 0
        for (int i = 0; i < 254; i++) begin
            d_raw = 1'b0; step(8);
            d_raw = 1'b1; step(8);
        end
        check("count_255", {8'd0, edge_count}, 16'd255);
        d_raw = 1'b0; step(8);
        d_raw = 1'b1; step(7);
        check_out("wrap", 1'b1, 1'b1, 1'b0, 8'd0);
        step(3);

        // 6c. final reset while high emits no fall
        fall_mark = fall_total;
        reset = 1'b1;
        step(1);
        check_out("final_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        step(2);
        check("final_fall_n", 16'(fall_total - fall_mark), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
